// File: rtl/muldiv_hilo_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its HI/LO registers.
package muldiv_hilo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_hilo_sign_mag.sv
// Two's-complement conditional negate of a value pair: either two independent
// W-bit halves, or (wide=1) one 2W-bit value negated under neg[1].
module muldiv_hilo_sign_mag
    import muldiv_hilo_pkg::*;
#(
    parameter int W = DEF_WIDTH
) (
    input  logic [2*W-1:0] val,
    input  logic           wide,
    input  logic [1:0]     neg,
    output logic [2*W-1:0] res
);

    // Negate the selected halves (or the whole value) when their flag is set
    always_comb begin
        res = val;
        if (wide) begin
            if (neg[1]) begin
                res = ~val + {{(2*W-1){1'b0}}, 1'b1};
            end else begin
                res = val;
            end
        end else begin
            if (neg[1]) begin
                res[2*W-1:W] = ~val[2*W-1:W] + {{(W-1){1'b0}}, 1'b1};
            end else begin
                res[2*W-1:W] = val[2*W-1:W];
            end
            if (neg[0]) begin
                res[W-1:0] = ~val[W-1:0] + {{(W-1){1'b0}}, 1'b1};
            end else begin
                res[W-1:0] = val[W-1:0];
            end
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Works on magnitudes; signs are re-applied in a single FIX cycle.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [1:0]           neg_r;
    logic                 is_mul_r;
    logic [WIDTH-1:0]     hi_r, lo_r;
    logic                 busy_r, done_r, dbz_r;
    logic [2*WIDTH-1:0]   mag_s, fix_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH+1:0]     div_diff_s;
    logic                 b_zero_s;

    assign b_zero_s = (B == {WIDTH{1'b0}});

    // {|A|, |B|} for the iterative datapath
    muldiv_hilo_sign_mag #(.W(WIDTH)) u_opnd_mag (
        .val  ({A, B}),
        .wide (1'b0),
        .neg  ({sign & A[WIDTH-1], sign & B[WIDTH-1]}),
        .res  (mag_s)
    );

    // Product is negated as one 2W value; quotient/remainder independently
    muldiv_hilo_sign_mag #(.W(WIDTH)) u_result_fix (
        .val  (acc_r),
        .wide (is_mul_r),
        .neg  (neg_r),
        .res  (fix_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection and single-iteration step values
    always_comb begin
        state_s     = state_r;
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        case (state_r)
            ST_IDLE: begin
                if (start && (op == OP_MULT)) begin
                    state_s = ST_MUL;
                end else if (start && (op == OP_DIV)) begin
                    state_s = ST_DIV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and architectural HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            neg_r    <= 2'b00;
            is_mul_r <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: begin
                                hi_r   <= A;
                                done_r <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_r   <= A;
                                done_r <= 1'b1;
                            end
                            OP_MULT: begin
                                opnd_r   <= mag_s[2*WIDTH-1:WIDTH];
                                acc_r    <= {{WIDTH{1'b0}}, mag_s[WIDTH-1:0]};
                                neg_r    <= {sign & (A[WIDTH-1] ^ B[WIDTH-1]), 1'b0};
                                is_mul_r <= 1'b1;
                                cnt_r    <= {CNT_W{1'b0}};
                                busy_r   <= 1'b1;
                            end
                            OP_DIV: begin
                                // Quotient sign is dropped on /0 so lo stays all ones and hi == A
                                opnd_r   <= mag_s[WIDTH-1:0];
                                acc_r    <= {{WIDTH{1'b0}}, mag_s[2*WIDTH-1:WIDTH]};
                                neg_r    <= {sign & A[WIDTH-1],
                                             sign & (A[WIDTH-1] ^ B[WIDTH-1]) & ~b_zero_s};
                                is_mul_r <= 1'b0;
                                dbz_r    <= b_zero_s;
                                cnt_r    <= {CNT_W{1'b0}};
                                busy_r   <= 1'b1;
                            end
                            default: begin
                                busy_r <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                ST_DIV: begin
                    if (!div_diff_s[WIDTH+1]) begin
                        acc_r <= {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_r <= {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                ST_FIX: begin
                    hi_r   <= fix_s[2*WIDTH-1:WIDTH];
                    lo_r   <= fix_s[WIDTH-1:0];
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
    assign dbz  = dbz_r;

endmodule
